cache_fill_fsm: RTL and testbench

- Miss-handling controller between the instruction/data caches and the multi-cycle main memory inside the memory subsystem.
- On a cache miss it fetches the whole 16-byte block (8 x 16-bit words) from main memory.
- It streams each returned word into the cache data array, then writes the tag array on the last word.
- While a fill is in progress it raises fsm_busy; the pipeline uses this signal to stall fetch (instruction cache) or memory (data cache).
- The memory subsystem instantiates one copy per cache.

---
 rtl/cache_fill_fsm.sv | 92 +++++++++
 tb/tb_cache_fill_fsm.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: fetches one aligned block from multi-cycle main memory,
// streams each returned word into the data array and writes the tag on the last word.
module cache_fill_fsm #(
  parameter int unsigned ADDR_W          = 16,
  parameter int unsigned WORDS_PER_BLOCK = 8,
  parameter int unsigned CNT_W           = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  input  logic [15:0]       memory_data,
  output logic              fsm_busy,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [ADDR_W-1:0] data_array_addr,
  output logic [15:0]       data_array_wdata,
  output logic              write_tag_array
);

  localparam int unsigned       OFF_W    = CNT_W + 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);
  localparam logic [CNT_W:0]    REQ_END  = (CNT_W + 1)'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0]  RCV_LAST = CNT_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] base;
  logic [CNT_W:0]    req_cnt;
  logic [CNT_W-1:0]  rcv_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      base    <= '0;
      req_cnt <= '0;
      rcv_cnt <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (miss_detected) begin
            base    <= miss_address & ~OFF_MASK;
            req_cnt <= '0;
            rcv_cnt <= '0;
          end
        end
        FILL: begin
          if (mem_rd_en)         req_cnt <= req_cnt + 1'b1;
          if (memory_data_valid) rcv_cnt <= rcv_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next       = state;
    fsm_busy         = 1'b0;
    mem_rd_en        = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    data_array_addr  = '0;
    write_tag_array  = 1'b0;
    data_array_wdata = memory_data;
    case (state)
      IDLE: begin
        // stall is raised combinationally in the miss cycle itself
        fsm_busy = miss_detected;
        if (miss_detected) state_next = FILL;
      end
      FILL: begin
        fsm_busy        = 1'b1;
        mem_rd_en       = (req_cnt < REQ_END);
        memory_address  = base + (ADDR_W'(req_cnt) << 1);
        data_array_addr = base + (ADDR_W'(rcv_cnt) << 1);
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          if (rcv_cnt == RCV_LAST) begin
            write_tag_array = 1'b1;
            state_next      = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm: a latency/gap-configurable memory model,
// a block-level reference model that queues expected requests/writes, and a monitor.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic        memory_data_valid = 1'b0;
  logic [15:0] memory_data = '0;
  logic        fsm_busy, mem_rd_en, write_data_array, write_tag_array;
  logic [15:0] memory_address, data_array_addr, data_array_wdata;

  cache_fill_fsm #(.ADDR_W(16), .WORDS_PER_BLOCK(8), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
    .memory_data_valid(memory_data_valid), .memory_data(memory_data),
    .fsm_busy(fsm_busy), .mem_rd_en(mem_rd_en), .memory_address(memory_address),
    .write_data_array(write_data_array), .data_array_addr(data_array_addr),
    .data_array_wdata(data_array_wdata), .write_tag_array(write_tag_array)
  );

  always #5 clk = ~clk;

  typedef struct {logic [15:0] addr; logic [15:0] data; logic tag;} wr_t;
  typedef struct {int unsigned due; logic [15:0] addr;} mreq_t;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  logic [15:0] salt;

  logic [15:0] exp_req[$];
  wr_t         exp_wr[$];
  mreq_t       pend[$];
  int unsigned req_cyc[$];

  bit          armed = 0;
  bit          active = 0;
  int unsigned miss_cyc = 0, tag_cyc = 0, tag_cnt = 0, wr_cnt = 0;

  int unsigned mem_lat = 4, mem_gap = 0, last_ret = 0;
  bit          noise = 0;

  function automatic logic [15:0] data_of(input logic [15:0] a);
    return (a * 16'h9E37) ^ salt;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: returns words in request order after mem_lat cycles, optional gaps.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      memory_data_valid = 1'b0;
      memory_data = 16'($urandom);
      if (pend.size() > 0 && pend[0].due <= cyc && (cyc - last_ret) > mem_gap) begin
        memory_data_valid = 1'b1;
        memory_data = data_of(pend[0].addr);
        last_ret = cyc;
        void'(pend.pop_front());
      end else if (noise) begin
        memory_data_valid = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor + reference model: outputs compared mid-cycle, model advanced afterwards.
  initial begin
    logic [15:0] ea;
    wr_t         ew;
    bit          done;
    forever begin
      @(negedge clk);
      if (armed) begin
        done = 0;
        check("busy", {15'd0, fsm_busy}, {15'd0, active || miss_detected});
        check("wdata_pass", data_array_wdata, memory_data);
        if (mem_rd_en === 1'b1) begin
          pend.push_back('{cyc + mem_lat, memory_address});
          req_cyc.push_back(cyc);
          if (exp_req.size() == 0) check("unexpected_req", memory_address, 16'hxxxx);
          else begin
            ea = exp_req.pop_front();
            check("req_addr", memory_address, ea);
          end
        end
        if (write_data_array === 1'b1) begin
          wr_cnt++;
          if (exp_wr.size() == 0) check("unexpected_write", data_array_addr, 16'hxxxx);
          else begin
            ew = exp_wr.pop_front();
            check("wr_addr", data_array_addr, ew.addr);
            check("wr_data", data_array_wdata, ew.data);
            check("wr_tag", {15'd0, write_tag_array}, {15'd0, ew.tag});
            if (ew.tag) begin
              done = 1;
              tag_cyc = cyc;
              tag_cnt++;
            end
          end
        end else begin
          check("stray_tag", {15'd0, write_tag_array}, 16'd0);
        end
        if (rst) begin
          active = 0;
          exp_req.delete();
          exp_wr.delete();
        end else if (active) begin
          if (done) active = 0;
        end else if (miss_detected) begin
          ea = miss_address & 16'hFFF0;
          for (int i = 0; i < 8; i++) begin
            exp_req.push_back(ea + 16'(2 * i));
            exp_wr.push_back('{ea + 16'(2 * i), data_of(ea + 16'(2 * i)), (i == 7)});
          end
          active = 1;
          miss_cyc = cyc;
          req_cyc.delete();
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_miss(input logic [15:0] a);
    miss_address = a;
    miss_detected = 1'b1;
    tick();
    miss_detected = 1'b0;
    miss_address = 16'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((active || exp_wr.size() != 0 || pend.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL fill_timeout: still busy after %0d cycles, required completion", budget);
    end
    check("req_queue_empty", 16'(exp_req.size()), 16'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    @(negedge clk);
    check({tag, "_busy"}, {15'd0, fsm_busy}, 16'd0);
    check({tag, "_rd_en"}, {15'd0, mem_rd_en}, 16'd0);
    check({tag, "_wde"}, {15'd0, write_data_array}, 16'd0);
    check({tag, "_wte"}, {15'd0, write_tag_array}, 16'd0);
    check({tag, "_mem_addr"}, memory_address, 16'd0);
    check({tag, "_da_addr"}, data_array_addr, 16'd0);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t0, n;
    salt = 16'($urandom);
    tick();
    armed = 1;
    tick();
    rst = 1'b0;

    // 1: idle with random valid noise
    noise = 1;
    for (int i = 0; i < 5; i++) check_idle_outputs("idle");
    noise = 0;
    tick();

    // 2: nominal fill, latency 4
    mem_lat = 4; mem_gap = 0;
    do_miss(16'h1236);
    wait_done(100);
    check("req_count", 16'(req_cyc.size()), 16'd8);
    if (req_cyc.size() == 8) begin
      check("first_req_cyc", 16'(req_cyc[0] - miss_cyc), 16'd1);
      check("last_req_cyc", 16'(req_cyc[7] - miss_cyc), 16'd8);
    end
    check("tag_cyc", 16'(tag_cyc - miss_cyc), 16'd12);

    // 3: gapped memory returns
    mem_gap = 2;
    t0 = tag_cnt;
    do_miss(16'($urandom));
    wait_done(200);
    check("gap_tag_count", 16'(tag_cnt - t0), 16'd1);

    // 4: top-of-space block, then back-to-back miss right after the tag write
    mem_gap = 0;
    t0 = tag_cnt;
    do_miss(16'hFFF2);
    n = 0;
    while (tag_cnt == t0 && n < 100) begin tick(); n++; end
    check("b2b_tag_seen", 16'(tag_cnt - t0), 16'd1);
    miss_address = 16'h0004;
    miss_detected = 1'b1;
    tick();
    miss_detected = 1'b0;
    wait_done(100);
    check("b2b_tag_count", 16'(tag_cnt - t0), 16'd2);

    // 5: reset after the 3rd returned word
    mem_gap = 2;
    t0 = wr_cnt;
    do_miss(16'h3A5C);
    n = 0;
    while (wr_cnt - t0 < 3 && n < 100) begin tick(); n++; end
    check("rst_words_before", 16'(wr_cnt - t0), 16'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    while (pend.size() != 0 && n < 100) begin tick(); n++; end
    check("rst_words_after", 16'(wr_cnt - t0), 16'd3);
    check_idle_outputs("post_rst");

    // 6: miss during an active fill is ignored
    mem_gap = 0;
    t0 = tag_cnt;
    do_miss(16'h2000);
    repeat (3) tick();
    miss_address = 16'h4000;
    miss_detected = 1'b1;
    tick();
    miss_detected = 1'b0;
    wait_done(100);
    check("ignore_tag_count", 16'(tag_cnt - t0), 16'd1);

    // random fills with random latency and gaps
    for (int k = 0; k < 6; k++) begin
      mem_lat = $urandom_range(1, 6);
      mem_gap = $urandom_range(0, 3);
      do_miss(16'($urandom));
      wait_done(300);
      repeat ($urandom_range(0, 2)) tick();
    end

    check("final_wr_queue", 16'(exp_wr.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
